// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//   Command/result bundle between the execute-stage ALU and the multi-cycle
//   shift sequencer.
//
//   Signals
//     start  ALU -> seq   command strobe, honoured only while busy is low
//     op     ALU -> seq   00=SLL 01=SRL 10=SRA 11=ROTR
//     shamt  ALU -> seq   shift amount, 0..WIDTH-1
//     in     ALU -> seq   operand
//     busy   seq -> ALU   command in progress
//     done   seq -> ALU   one-cycle pulse, out holds a fresh result
//     out    seq -> ALU   result, held until the next done
//
//   Modports
//     master  the ALU side that issues commands
//     slave   the sequencer side that executes them
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);

    logic               start;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   in;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out;

    modport master (
        output start,
        output op,
        output shamt,
        output in,
        input  busy,
        input  done,
        input  out
    );

    modport slave (
        input  start,
        input  op,
        input  shamt,
        input  in,
        output busy,
        output done,
        output out
    );

endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle controller for the single-bit shift datapath of the MIPS
//   execute stage. One command (SLL/SRL/SRA/ROTR plus amount) is captured
//   into an accumulator and shifted by one bit position per clock; once the
//   remaining count reaches zero the accumulator is published on out with a
//   one-cycle done pulse. This replaces a combinational barrel shifter with a
//   start/busy/done handshake.
//
//   Parameters
//     WIDTH    data width of operand and result
//     SHAMT_W  shift-amount width, 2**SHAMT_W must cover WIDTH
//
//   Ports
//     clk    clock, every state update on the rising edge
//     reset  synchronous, active-high; aborts any command in flight
//     bus    shift_sequencer_if.slave (start/op/shamt/in, busy/done/out)
//
//   Timing
//     The command is accepted on the edge that sees start high in IDLE.
//     done rises exactly shamt+1 edges later, busy is high for those
//     shamt+1 cycles, and start during the done cycle is accepted at once.
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_sequencer_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } shift_op_t;

    state_t             state;
    state_t             state_next;
    shift_op_t          op_q;
    shift_op_t          op_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   acc_shifted;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] count_next;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   out_next;
    logic               done_q;
    logic               done_next;

    // One-bit step of the accumulator for the latched operation. SRA refills
    // the vacated MSB with the old sign bit, ROTR refills it with the bit
    // that falls out of the LSB.
    always_comb begin
        acc_shifted = acc;
        case (op_q)
            OP_SLL:  acc_shifted = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_shifted = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROTR: acc_shifted = {acc[0], acc[WIDTH-1:1]};
            default: acc_shifted = acc;
        endcase
    end

    // Next-state logic. Everything holds by default; done defaults low so
    // that it can only ever be a single-cycle pulse. In SHIFT the command
    // inputs are not looked at, which is what makes start, op, shamt and in
    // irrelevant while busy.
    always_comb begin
        state_next = state;
        op_next    = op_q;
        acc_next   = acc;
        count_next = count;
        out_next   = out_q;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = bus.in;
                    count_next = bus.shamt;
                    op_next    = shift_op_t'(bus.op);
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (count != '0) begin
                    acc_next   = acc_shifted;
                    count_next = count - SHAMT_W'(1);
                end else begin
                    // Count exhausted: the accumulator already holds the
                    // full result, so publish it and free the unit.
                    out_next   = acc;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset is synchronous and wins over everything,
    // including a command half way through its shift, which is simply
    // dropped without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= OP_SLL;
            acc    <= '0;
            count  <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            op_q   <= op_next;
            acc    <= acc_next;
            count  <= count_next;
            out_q  <= out_next;
            done_q <= done_next;
        end
    end

    // busy is exactly "a command occupies the datapath", i.e. the SHIFT state.
    assign bus.busy = (state == SHIFT);
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//   Self-checking bench for shift_sequencer. Directed commands cover the
//   known-answer cases, busy-time noise, back-to-back issue and a mid-shift
//   reset; a long random run compares every result and latency against a
//   reference that computes shifts with plain SystemVerilog operators.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic clk;
    logic reset;

    int compareCount;
    int mismatchCount;

    shift_sequencer_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result straight from the operation's definition.
    function automatic logic [WIDTH-1:0] refShift(input logic [1:0] o,
                                                  input int s,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $unsigned($signed(d) >>> s);
            default: r = (s == 0) ? d : ((d >> s) | (d << (WIDTH - s)));
        endcase
        return r;
    endfunction

    // Single comparison point: counts every check and reports a mismatch.
    task automatic checkOutput(input string tag,
                               input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h",
                     tag, observed, expected);
        end
    endtask

    // Issue one command and follow it to completion. Called at #1 after a
    // rising edge with the unit idle (or in a done cycle); returns at #1 after
    // the done edge, so a follow-up call is accepted with no idle gap. With
    // noise set, start and all operands are scrambled while busy, and out is
    // required to stay frozen until the done edge.
    task automatic applyStimulus(input string tag,
                                 input logic [1:0] o,
                                 input int s,
                                 input logic [WIDTH-1:0] d,
                                 input bit noise);
        logic [WIDTH-1:0] expected;
        logic [WIDTH-1:0] heldOut;
        int cycles;
        bit outMoved;

        expected = refShift(o, s, d);
        heldOut  = bus.out;
        bus.start = 1'b1;
        bus.op    = o;
        bus.shamt = SHAMT_W'(s);
        bus.in    = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput({tag, ".busy_after_accept"}, WIDTH'(bus.busy), WIDTH'(1));

        cycles   = 0;
        outMoved = 1'b0;
        while (!bus.done && cycles < 40) begin
            if (noise) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom);
                bus.shamt = SHAMT_W'($urandom);
                bus.in    = WIDTH'($urandom);
            end
            if (bus.out !== heldOut)
                outMoved = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.start = 1'b0;

        checkOutput({tag, ".latency"}, WIDTH'(cycles), WIDTH'(s + 1));
        checkOutput({tag, ".result"}, bus.out, expected);
        checkOutput({tag, ".busy_at_done"}, WIDTH'(bus.busy), WIDTH'(0));
        if (noise)
            checkOutput({tag, ".out_held_while_busy"}, WIDTH'(outMoved), WIDTH'(0));
    endtask

    initial begin
        bit sawDone;
        int idleGap;

        compareCount  = 0;
        mismatchCount = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.shamt = '0;
        bus.in    = '0;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset.busy", WIDTH'(bus.busy), WIDTH'(0));
        checkOutput("reset.done", WIDTH'(bus.done), WIDTH'(0));
        checkOutput("reset.out", bus.out, '0);

        // Known-answer commands.
        applyStimulus("sll2", 2'b00, 2, 32'hDCFF_FFFF, 1'b0);
        checkOutput("sll2.known", bus.out, 32'h73FF_FFFC);
        @(posedge clk);
        #1;
        checkOutput("sll2.done_one_cycle", WIDTH'(bus.done), WIDTH'(0));
        checkOutput("sll2.out_held", bus.out, 32'h73FF_FFFC);

        applyStimulus("sra4", 2'b10, 4, 32'hDCFF_FFFF, 1'b0);
        checkOutput("sra4.known", bus.out, 32'hFDCF_FFFF);
        applyStimulus("srl31", 2'b01, 31, 32'h8000_0000, 1'b0);
        checkOutput("srl31.known", bus.out, 32'h0000_0001);
        applyStimulus("rotr8", 2'b11, 8, 32'h1234_5678, 1'b0);
        checkOutput("rotr8.known", bus.out, 32'h7812_3456);
        for (int o = 0; o < 4; o++) begin
            applyStimulus($sformatf("zero_op%0d", o), 2'(o), 0, 32'hA5A5_A5A5, 1'b0);
            checkOutput($sformatf("zero_op%0d.known", o), bus.out, 32'hA5A5_A5A5);
        end

        // Start held with changing operands while busy, then back-to-back.
        applyStimulus("noisy_sll", 2'b00, 7, 32'h0F0F_1234, 1'b1);
        applyStimulus("b2b_rotr", 2'b11, 31, 32'h8000_0001, 1'b0);

        // Reset five cycles into a long SLL.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.shamt = SHAMT_W'(20);
        bus.in    = 32'hFFFF_0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midreset.busy", WIDTH'(bus.busy), WIDTH'(0));
        checkOutput("midreset.done", WIDTH'(bus.done), WIDTH'(0));
        checkOutput("midreset.out", bus.out, '0);
        sawDone = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy)
                sawDone = 1'b1;
        end
        checkOutput("midreset.no_late_done", WIDTH'(sawDone), WIDTH'(0));
        applyStimulus("after_reset", 2'b10, 5, 32'h8765_4321, 1'b0);

        // Random commands, occasionally with busy-time noise or idle gaps.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus($sformatf("rand%0d", n), 2'($urandom),
                          int'($urandom_range(0, WIDTH - 1)),
                          WIDTH'($urandom), 1'($urandom_range(0, 7) == 0));
            idleGap = int'($urandom_range(0, 3));
            if (idleGap != 0) begin
                repeat (idleGap) @(posedge clk);
                #1;
                checkOutput($sformatf("rand%0d.done_dropped", n), WIDTH'(bus.done), WIDTH'(0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
